// File: rtl/sprite_line_sequencer.sv
// Sprite line sequencer: scans the OAM once per requested line, collects the
// addresses of the sprites that cover that line into a small secondary array
// (lowest OAM address first), then hands the line to the sprite drawer and
// waits for it to finish.
module sprite_line_sequencer #(
   parameter int OAM_ADDR_SIZE     = 8,
   parameter int OAM_DATA_SIZE     = 32,
   parameter int SECOND_ARRAY_SIZE = 32,
   parameter int SPRITE_HEIGHT     = 16,
   parameter int DISPLAY_HEIGHT    = 480,
   localparam int LINE_NUMBER_WIDTH = $clog2(DISPLAY_HEIGHT)
) (
   input  logic                                                clk,
   input  logic                                                rst,
   input  logic                                                line_start,
   input  logic [LINE_NUMBER_WIDTH-1:0]                        line_number,
   output wire  [OAM_ADDR_SIZE-1:0]                            oam_a,
   input  logic [OAM_DATA_SIZE-1:0]                            oam_d,
   output logic [SECOND_ARRAY_SIZE-1:0][OAM_ADDR_SIZE:0]       second_array,
   output logic                                                drawer_enable,
   input  logic                                                drawer_done,
   output logic                                                line_ready,
   output logic                                                busy,
   output logic                                                overflow,
   output logic                                                line_overrun
);

   // Enough bits to count from 0 up to and including SECOND_ARRAY_SIZE.
   localparam int FILL_W = $clog2(SECOND_ARRAY_SIZE + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DRAW,
      S_FINISH
   } state_t;

   state_t                         state_q, state_d;
   logic [OAM_ADDR_SIZE-1:0]       addr_q, addr_d;           // next OAM address to issue
   logic                           addr_last_q, addr_last_d; // last address already issued
   logic                           eval_valid_q, eval_valid_d;
   logic [OAM_ADDR_SIZE-1:0]       eval_addr_q, eval_addr_d; // address whose data is on oam_d
   logic [LINE_NUMBER_WIDTH-1:0]   line_q, line_d;
   logic [FILL_W-1:0]              fill_q, fill_d;           // number of occupied slots
   logic                           overflow_q, overflow_d;
   logic                           overrun_q, overrun_d;
   logic                           slots_clear;
   logic                           slot_write;

   logic [OAM_ADDR_SIZE:0]         slot_q [SECOND_ARRAY_SIZE];

   // OAM word fields. Only enable and ypos matter for the hit test; the
   // remaining bits belong to the drawer.
   logic                           obj_enable;
   logic [9:0]                     obj_ypos;
   logic [9:0]                     line_ext;
   logic [9:0]                     y_delta;
   logic                           hit;
   logic                           oam_unused;

   assign obj_enable = oam_d[31];
   assign obj_ypos   = oam_d[27:18];
   assign line_ext   = 10'(line_q);
   assign y_delta    = line_ext - obj_ypos;
   // The ypos <= line guard stops a sprite near the bottom of the 10-bit
   // coordinate space from wrapping onto the first lines.
   assign hit        = obj_enable && (line_ext >= obj_ypos) &&
                       (y_delta < 10'(SPRITE_HEIGHT));
   assign oam_unused = ^oam_d;

   // Next-state and datapath control for the line sequencer.
   always_comb begin
      state_d      = state_q;
      addr_d       = addr_q;
      addr_last_d  = addr_last_q;
      eval_valid_d = 1'b0;
      eval_addr_d  = eval_addr_q;
      line_d       = line_q;
      fill_d       = fill_q;
      overflow_d   = overflow_q;
      overrun_d    = overrun_q;
      slots_clear  = 1'b0;
      slot_write   = 1'b0;

      if (line_start && (state_q != S_IDLE)) begin
         overrun_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (line_start) begin
               line_d      = line_number;
               slots_clear = 1'b1;
               overflow_d  = 1'b0;
               fill_d      = '0;
               addr_d      = '0;
               addr_last_d = 1'b0;
               state_d     = S_SCAN;
            end
         end

         S_SCAN: begin
            // Issue side: one address per cycle, saturating at the last one.
            if (!addr_last_q) begin
               eval_valid_d = 1'b1;
               eval_addr_d  = addr_q;
               if (addr_q == '1) begin
                  addr_last_d = 1'b1;
               end else begin
                  addr_d = addr_q + 1'b1;
               end
            end
            // Evaluate side: data arrives one cycle after its address.
            if (eval_valid_q) begin
               if (hit) begin
                  if (fill_q < FILL_W'(SECOND_ARRAY_SIZE)) begin
                     slot_write = 1'b1;
                     fill_d     = fill_q + 1'b1;
                  end else begin
                     overflow_d = 1'b1;
                  end
               end
               if (eval_addr_q == '1) begin
                  state_d = S_DRAW;
               end
            end
         end

         S_DRAW: begin
            if (drawer_done) begin
               state_d = S_FINISH;
            end
         end

         S_FINISH: begin
            state_d = S_IDLE;
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and control registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         addr_q       <= '0;
         addr_last_q  <= 1'b0;
         eval_valid_q <= 1'b0;
         eval_addr_q  <= '0;
         line_q       <= '0;
         fill_q       <= '0;
         overflow_q   <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         addr_q       <= addr_d;
         addr_last_q  <= addr_last_d;
         eval_valid_q <= eval_valid_d;
         eval_addr_q  <= eval_addr_d;
         line_q       <= line_d;
         fill_q       <= fill_d;
         overflow_q   <= overflow_d;
         overrun_q    <= overrun_d;
      end
   end

   // Secondary array: slots fill strictly in order, so the lowest free slot
   // is always the one indexed by the fill count.
   genvar gi;
   generate
      for (gi = 0; gi < SECOND_ARRAY_SIZE; gi++) begin : g_slot
         // One slot register: cleared on reset or line accept, written on a hit.
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               slot_q[gi] <= '0;
            end else if (slots_clear) begin
               slot_q[gi] <= '0;
            end else if (slot_write && (fill_q == FILL_W'(gi))) begin
               slot_q[gi] <= {eval_addr_q, 1'b1};
            end
         end
         assign second_array[gi] = slot_q[gi];
      end
   endgenerate

   // The OAM bus is only driven while scanning.
   assign oam_a         = (state_q == S_SCAN) ? addr_q : {OAM_ADDR_SIZE{1'bz}};
   assign drawer_enable = (state_q == S_DRAW);
   assign line_ready    = (state_q == S_FINISH);
   assign busy          = (state_q != S_IDLE);
   assign overflow      = overflow_q;
   assign line_overrun  = overrun_q;

endmodule
